axi_bridge_arb: RTL and testbench
=================================

# axi_bridge_arb

Arbiter and sequencer sharing one AXI master port between the instruction-fetch port (read-only) and the data-memory port (read/write) of the five-stage LoongArch pipeline. It converts the SRAM-like request/addr_ok/data_ok handshakes of both ports into AXI AR/R and AW/W/B transactions. It allows at most one outstanding read and one outstanding write. It enforces read-after-write ordering for data accesses and returns each response to its owner.

## Interface
- No parameters; address and data are 32 bit, IDs are 4 bit.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- inst_req  in  1  fetch read request.
- inst_addr  in  32  fetch address.
- inst_size  in  2  log2 bytes.
- inst_addr_ok  out  1  fetch request accepted this cycle.
- inst_data_ok  out  1  fetch data valid pulse.
- inst_rdata  out  32  fetch data.
- data_req  in  1  data request.
- data_wr  in  1  1 = write.
- data_size  in  2  log2 bytes.
- data_addr  in  32  address.
- data_wstrb  in  4  byte enables.
- data_wdata  in  32  write data.
- data_addr_ok  out  1  data request accepted.
- data_data_ok  out  1  data response pulse (read data or write done).
- data_rdata  out  32  load data.
- arid/araddr/arsize/arvalid  out  4/32/3/1; arready  in  1.
- rid/rdata/rvalid  in  4/32/1; rready  out  1.
- awaddr/awsize/awvalid  out  32/3/1; awready  in  1.
- wdata/wstrb/wvalid  out  32/4/1; wready  in  1.
- bvalid  in  1; bready  out  1.
- Constant outputs: arlen = awlen = 0, arburst = awburst = 2'b01, awid = 1, wid = 1, wlast = 1, lock/cache/prot = 0.

## Operation
- Read FSM states:
  - R_IDLE to R_AR on accept.
  - R_AR to R_WAIT on arvalid&&arready.
  - R_WAIT to R_IDLE on rvalid&&rready.
- Read accept in R_IDLE:
  - Data read (data_req&&!data_wr&&!raw_block) has priority over inst_req.
  - The winner gets addr_ok high that cycle, combinationally.
  - araddr, arsize ({1'b0,size}) and owner are latched; arid = 0 for inst, 1 for data.
- Write FSM states:
  - W_IDLE to W_AW on accept (data_req&&data_wr).
  - In W_AW, awvalid and wvalid are raised together; each drops independently on its own handshake.
  - W_AW to W_B when both handshakes are done, including the case where both complete in the same cycle.
  - W_B to W_IDLE on bvalid&&bready.
- A data write and an inst read may both be accepted in the same cycle.
- When data_req&&data_wr, a data read is never accepted in that cycle.
- raw_block is 1 while the write FSM is not W_IDLE (see Configuration). Inst reads are never blocked.
- Read response:
  - rready = (R_WAIT) && !(owner==data && W_B && bvalid). A B response wins the data_data_ok slot.
  - inst_data_ok = rvalid&&rready&&owner==inst.
  - Read data passes through from rdata to inst_rdata/data_rdata.
  - rid is ignored; routing uses the latched owner.
- Write response: bready = (W_B); data_data_ok also pulses on bvalid&&bready.
- Outputs are held stable while valid and not yet handshaken.

## Timing
- Reset: both FSMs idle, all valid/ready/ok outputs 0, latched address/data 0.
- Reset mid-transaction aborts the transaction; no response is returned.
- Read latency: accept at cycle N, arvalid at N+1. data_ok arrives in the cycle rvalid is seen in R_WAIT. Minimum is 3 cycles for arready=rvalid=1.
- Write latency: accept at N, awvalid/wvalid at N+1, data_ok on the B handshake. Minimum is 3 cycles.
- No back-to-back read acceptance: the next read accept is possible in the cycle after R_WAIT exits.

## Configuration
- ARB_RAW_ADDR_CHECK_EN defined:
  - raw_block = (write FSM != W_IDLE) && (data_addr[31:2] == latched awaddr[31:2]).
  - Data reads to other words proceed in parallel with the write.
- Undefined: any outstanding write blocks all data reads.

## Test plan
- Inst and data read requested together in R_IDLE → data_addr_ok=1 and inst_addr_ok=0; arid=1. After rvalid with rdata=0x1234_5678: data_data_ok=1, data_rdata=0x1234_5678, inst not acked.
- Data store 0x0000_1000 with wstrb=4'b0011, awready low 3 cycles, wready=1 → wvalid drops after 1 cycle and awvalid is held. W_B is entered after the AW handshake; data_data_ok pulses on bvalid.
- Write to 0x1000 outstanding, then data read from 0x1000 → data_addr_ok=0 until the B handshake, accepted the next cycle. Read from 0x2000: blocked without the macro, accepted immediately with ARB_RAW_ADDR_CHECK_EN.
- With the macro, a data read R_WAIT and W_B both receive valid responses in the same cycle → bready completes and rready=0. Read data_ok follows one cycle later; exactly one data_data_ok per cycle.
- Inst read accepted the same cycle as a data write → both AXI channels become active at N+1. inst_data_ok and data_data_ok may pulse in the same cycle.
- Reset asserted in R_WAIT → next cycle arvalid=rready=0, both FSMs idle, no data_ok pulse.

Source files
------------

// File: rtl/axi_bridge_arb.sv
// Shares one AXI master port between the fetch (read-only) and data (read/write) SRAM-like ports.
// Optional ARB_RAW_ADDR_CHECK_EN: block data reads only when they hit the word of the outstanding write.
module axi_bridge_arb (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  input  logic [1:0]  inst_size,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [1:0] {R_IDLE, R_AR, R_WAIT} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_B} w_state_t;

  r_state_t r_state, r_next;
  w_state_t w_state, w_next;

  logic        r_owner;   // 0 = inst, 1 = data
  logic [31:0] araddr_q;
  logic [2:0]  arsize_q;
  logic [31:0] awaddr_q;
  logic [2:0]  awsize_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        aw_done, w_done;

  logic raw_block, data_rd_go, inst_rd_go, wr_go, aw_hs, w_hs;
  logic unused_rid;

  assign unused_rid = ^rid;

`ifdef ARB_RAW_ADDR_CHECK_EN
  assign raw_block = (w_state != W_IDLE) && (data_addr[31:2] == awaddr_q[31:2]);
`else
  assign raw_block = (w_state != W_IDLE);
`endif

  // A data read is only a candidate when it could actually be accepted; otherwise fetch goes.
  assign data_rd_go = (r_state == R_IDLE) && data_req && !data_wr && !raw_block;
  assign inst_rd_go = (r_state == R_IDLE) && inst_req && !data_rd_go;
  assign wr_go      = (w_state == W_IDLE) && data_req && data_wr;

  assign inst_addr_ok = inst_rd_go;
  assign data_addr_ok = data_rd_go || wr_go;

  assign arid    = {3'b000, r_owner};
  assign araddr  = araddr_q;
  assign arsize  = arsize_q;
  assign arlen   = 4'd0;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign arvalid = (r_state == R_AR);

  assign awid    = 4'd1;
  assign awaddr  = awaddr_q;
  assign awsize  = awsize_q;
  assign awlen   = 4'd0;
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign awvalid = (w_state == W_AW) && !aw_done;

  assign wid    = 4'd1;
  assign wdata  = wdata_q;
  assign wstrb  = wstrb_q;
  assign wlast  = 1'b1;
  assign wvalid = (w_state == W_AW) && !w_done;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;

  // The B response owns the data_data_ok slot; a data read response waits a cycle.
  assign bready = (w_state == W_B);
  assign rready = (r_state == R_WAIT) && !(r_owner && (w_state == W_B) && bvalid);

  assign inst_rdata   = rdata;
  assign data_rdata   = rdata;
  assign inst_data_ok = rvalid && rready && !r_owner;
  assign data_data_ok = (rvalid && rready && r_owner) || (bvalid && bready);

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (data_rd_go || inst_rd_go) r_next = R_AR;
      R_AR:    if (arvalid && arready)       r_next = R_WAIT;
      R_WAIT:  if (rvalid && rready)         r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (wr_go) w_next = W_AW;
      W_AW:    if ((aw_done || aw_hs) && (w_done || w_hs)) w_next = W_B;
      W_B:     if (bvalid && bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= R_IDLE;
      r_owner  <= 1'b0;
      araddr_q <= 32'd0;
      arsize_q <= 3'd0;
    end else begin
      r_state <= r_next;
      if (data_rd_go) begin
        r_owner  <= 1'b1;
        araddr_q <= data_addr;
        arsize_q <= {1'b0, data_size};
      end else if (inst_rd_go) begin
        r_owner  <= 1'b0;
        araddr_q <= inst_addr;
        arsize_q <= {1'b0, inst_size};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_state  <= W_IDLE;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      awaddr_q <= 32'd0;
      awsize_q <= 3'd0;
      wdata_q  <= 32'd0;
      wstrb_q  <= 4'd0;
    end else begin
      w_state <= w_next;
      // Handshake-done flags only live inside W_AW; they clear on any other state.
      aw_done <= (w_state == W_AW) && (aw_done || aw_hs);
      w_done  <= (w_state == W_AW) && (w_done || w_hs);
      if (wr_go) begin
        awaddr_q <= data_addr;
        awsize_q <= {1'b0, data_size};
        wdata_q  <= data_wdata;
        wstrb_q  <= data_wstrb;
      end
    end
  end

endmodule

// File: tb/tb_axi_bridge_arb.sv
// Directed bench for axi_bridge_arb; expected responses go to per-owner queues checked by a monitor.
module tb_axi_bridge_arb;
  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic [1:0]  inst_size;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0]  data_wstrb;
  logic [3:0]  arid, arlen, arcache, awid, awlen, awcache, wid, wstrb, rid;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [2:0]  arsize, arprot, awsize, awprot;
  logic [1:0]  arburst, arlock, awburst, awlock;
  logic        arvalid, arready, rvalid, rready, awvalid, awready;
  logic        wlast, wvalid, wready, bvalid, bready;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] inst_q[$];
  logic [31:0] drd_q[$];
  bit          dwr_q[$];

  axi_bridge_arb dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_size(inst_size),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive just after the edge; checks are made 1 time unit later, away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (inst_data_ok) begin
      if (inst_q.size() == 0) chk("inst_unexpected_ok", 32'd1, 32'd0);
      else chk("inst_rdata", inst_rdata, inst_q.pop_front());
    end
    if (data_data_ok) begin
      if (bvalid && bready) begin
        if (dwr_q.size() == 0) chk("data_unexpected_bok", 32'd1, 32'd0);
        else void'(dwr_q.pop_front());
      end else if (drd_q.size() == 0) chk("data_unexpected_rok", 32'd1, 32'd0);
      else chk("data_rdata", data_rdata, drd_q.pop_front());
    end
  end

  initial begin
    logic [31:0] exp_far;
    reset = 1'b1;
    inst_req = 0; inst_addr = 0; inst_size = 2'd2;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = 0; data_wstrb = 0; data_wdata = 0;
    arready = 0; rid = 0; rdata = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
    tick(); tick();
    chk("rst_arvalid", {31'd0, arvalid}, 0);
    chk("rst_awvalid", {31'd0, awvalid}, 0);
    chk("rst_wvalid",  {31'd0, wvalid}, 0);
    chk("rst_rready",  {31'd0, rready}, 0);
    chk("rst_bready",  {31'd0, bready}, 0);
    chk("rst_araddr",  araddr, 0);
    chk("rst_awaddr",  awaddr, 0);
    reset = 1'b0;
    tick();

    // Simultaneous inst and data read: data wins
    inst_req = 1; inst_addr = 32'h100;
    data_req = 1; data_wr = 0; data_addr = 32'h200;
    #1;
    chk("pri_data_addr_ok", {31'd0, data_addr_ok}, 1);
    chk("pri_inst_addr_ok", {31'd0, inst_addr_ok}, 0);
    drd_q.push_back(32'h1234_5678);
    tick();
    inst_req = 0; data_req = 0; arready = 1;
    #1;
    chk("pri_arvalid", {31'd0, arvalid}, 1);
    chk("pri_arid",    {28'd0, arid}, 1);
    chk("pri_araddr",  araddr, 32'h200);
    chk("pri_arsize",  {29'd0, arsize}, 2);
    tick();
    arready = 0; rvalid = 1; rdata = 32'h1234_5678;
    #1;
    chk("pri_rready",    {31'd0, rready}, 1);
    chk("pri_inst_nook", {31'd0, inst_data_ok}, 0);
    chk("pri_data_ok",   {31'd0, data_data_ok}, 1);
    tick();
    rvalid = 0;

    // Store with AW stalled three cycles
    data_req = 1; data_wr = 1; data_addr = 32'h1000; data_size = 2'd1;
    data_wstrb = 4'b0011; data_wdata = 32'hA5A5_5A5A; wready = 1; awready = 0;
    #1;
    chk("st_addr_ok", {31'd0, data_addr_ok}, 1);
    dwr_q.push_back(1'b1);
    tick();
    data_req = 0; data_wr = 0; data_size = 2'd2;
    #1;
    chk("st_awvalid1", {31'd0, awvalid}, 1);
    chk("st_wvalid1",  {31'd0, wvalid}, 1);
    chk("st_awaddr",   awaddr, 32'h1000);
    chk("st_awsize",   {29'd0, awsize}, 1);
    chk("st_wstrb",    {28'd0, wstrb}, 32'h3);
    chk("st_wdata",    wdata, 32'hA5A5_5A5A);
    tick();
    chk("st_wvalid2",  {31'd0, wvalid}, 0);
    chk("st_awvalid2", {31'd0, awvalid}, 1);
    chk("st_bready2",  {31'd0, bready}, 0);
    tick();
    chk("st_awvalid3", {31'd0, awvalid}, 1);
    awready = 1;
    tick();
    awready = 0;
    chk("st_awvalid_b", {31'd0, awvalid}, 0);
    chk("st_bready",    {31'd0, bready}, 1);

    // RAW: same-word read blocked, other-word read depends on the address check
    data_req = 1; data_wr = 0; data_addr = 32'h2000;
`ifdef ARB_RAW_ADDR_CHECK_EN
    exp_far = 1;
`else
    exp_far = 0;
`endif
    #1;
    chk("raw_far_addr_ok", {31'd0, data_addr_ok}, exp_far);
    data_addr = 32'h1000;
    #1;
    chk("raw_same_blocked", {31'd0, data_addr_ok}, 0);
    bvalid = 1;
    #1;
    chk("raw_b_blocked", {31'd0, data_addr_ok}, 0);
    chk("raw_b_ok",      {31'd0, data_data_ok}, 1);
    tick();
    bvalid = 0;
    #1;
    chk("raw_release", {31'd0, data_addr_ok}, 1);
    drd_q.push_back(32'hCAFE_0001);
    tick();
    data_req = 0; arready = 1;
    #1;
    chk("raw_araddr", araddr, 32'h1000);
    tick();
    arready = 0; rvalid = 1; rdata = 32'hCAFE_0001;
    tick();
    rvalid = 0;

    // Data read in flight, write accepted behind it; B and R arrive together
    data_req = 1; data_wr = 0; data_addr = 32'h3000;
    #1;
    chk("rb_rd_addr_ok", {31'd0, data_addr_ok}, 1);
    drd_q.push_back(32'h3333_3333);
    tick();
    data_wr = 1; data_addr = 32'h4000; data_wdata = 32'h44; data_wstrb = 4'hF;
    arready = 1; awready = 1; wready = 1;
    #1;
    chk("rb_wr_addr_ok", {31'd0, data_addr_ok}, 1);
    dwr_q.push_back(1'b1);
    tick();
    data_req = 0; data_wr = 0; arready = 0;
    tick();
    awready = 0; wready = 0;
    rvalid = 1; rdata = 32'h3333_3333; bvalid = 1;
    #1;
    chk("rb_rready_held", {31'd0, rready}, 0);
    chk("rb_bready",      {31'd0, bready}, 1);
    tick();
    bvalid = 0;
    #1;
    chk("rb_rready_next", {31'd0, rready}, 1);
    chk("rb_rd_ok",       {31'd0, data_data_ok}, 1);
    tick();
    rvalid = 0;

    // Inst read and data write accepted together
    inst_req = 1; inst_addr = 32'h500;
    data_req = 1; data_wr = 1; data_addr = 32'h600; data_wdata = 32'h66;
    #1;
    chk("iw_inst_ok", {31'd0, inst_addr_ok}, 1);
    chk("iw_data_ok", {31'd0, data_addr_ok}, 1);
    inst_q.push_back(32'h5555_0000);
    dwr_q.push_back(1'b1);
    tick();
    inst_req = 0; data_req = 0; data_wr = 0;
    arready = 1; awready = 1; wready = 1;
    #1;
    chk("iw_arvalid", {31'd0, arvalid}, 1);
    chk("iw_arid",    {28'd0, arid}, 0);
    chk("iw_araddr",  araddr, 32'h500);
    chk("iw_awvalid", {31'd0, awvalid}, 1);
    chk("iw_wvalid",  {31'd0, wvalid}, 1);
    tick();
    arready = 0; awready = 0; wready = 0;
    rvalid = 1; rdata = 32'h5555_0000; bvalid = 1;
    #1;
    chk("iw_both_inst", {31'd0, inst_data_ok}, 1);
    chk("iw_both_data", {31'd0, data_data_ok}, 1);
    tick();
    rvalid = 0; bvalid = 0;

    // Reset while waiting for R
    inst_req = 1; inst_addr = 32'h700;
    tick();
    inst_req = 0; arready = 1;
    tick();
    arready = 0;
    #1;
    chk("rs_rready_pre", {31'd0, rready}, 1);
    reset = 1;
    tick();
    rvalid = 1; rdata = 32'hDEAD_BEEF;
    #1;
    chk("rs_rready",   {31'd0, rready}, 0);
    chk("rs_arvalid",  {31'd0, arvalid}, 0);
    chk("rs_inst_ok",  {31'd0, inst_data_ok}, 0);
    chk("rs_araddr",   araddr, 0);
    reset = 0;
    tick();
    #1;
    chk("rs_no_ok", {31'd0, inst_data_ok}, 0);
    rvalid = 0;
    tick(); tick();

    chk("q_inst_empty", inst_q.size(), 0);
    chk("q_drd_empty",  drd_q.size(), 0);
    chk("q_dwr_empty",  dwr_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
